// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. It issues 4-word read bursts to memory and
//   pushes the returned words with their byte addresses into an 8-entry
//   instruction FIFO. The decode stage drains the FIFO through a valid/ready
//   handshake. A redirect flushes the FIFO and restarts fetch at a new address.
//   Any beats still outstanding from the current burst are discarded.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   mem_addr          : burst start byte address (0 unless mem_enable)
//   mem_enable        : one-cycle burst request strobe
//   mem_rd_wr         : constant 1 (read)
//   mem_access_size   : constant 2'b01 (4-word burst)
//   mem_busy          : memory busy; blocks a new request
//   mem_data_out      : read data, one word per BEAT cycle
//   inst, inst_pc     : FIFO head word and its byte address (0 when empty)
//   inst_valid        : FIFO non-empty
//   inst_ready        : decode accepts the head this cycle
//   redirect          : flush and restart fetch at redirect_pc
//   redirect_pc       : restart byte address, bits [1:0] ignored
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h80020000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   output logic        mem_enable,
   output logic        mem_rd_wr,
   output logic [1:0]  mem_access_size,
   input  logic        mem_busy,
   input  logic [31:0] mem_data_out,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int DEPTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_BEAT = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  beat_q, beat_d;
   logic        drop_q, drop_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] base_q, base_d;

   logic [31:0] fifo_inst_q [DEPTH];
   logic [31:0] fifo_pc_q   [DEPTH];
   logic [2:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  wr_ptr_q, wr_ptr_d;
   logic [3:0]  count_q, count_d;

   logic        push, pop;
   logic [31:0] beat_pc;

   // Low address bits of the redirect target are deliberately dropped.
   logic unused_rpc;
   assign unused_rpc = ^redirect_pc[1:0];

   // ---------------------------------------------------------------- outputs
   assign mem_rd_wr       = 1'b1;
   assign mem_access_size = 2'b01;
   assign mem_enable      = (state_q == S_REQ) && !reset;
   assign mem_addr        = mem_enable ? fetch_pc_q : 32'd0;

   assign inst_valid = (count_q != 4'd0) && !reset;
   assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;
   assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'd0;

   // A redirect voids both handshakes in its cycle. The full check is only a
   // guard: the IDLE admission rule (count <= 4) already rules out overflow.
   assign beat_pc = base_q + {28'd0, beat_q, 2'b00};
   assign push    = (state_q == S_BEAT) && !drop_q && !redirect
                    && (count_q != 4'(DEPTH));
   assign pop     = inst_valid && inst_ready && !redirect;

   // ------------------------------------------------------------------- FSM
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      drop_d     = drop_q;
      fetch_pc_d = fetch_pc_q;
      base_d     = base_q;

      case (state_q)
         S_IDLE: begin
            if ((count_q <= 4'd4) && !mem_busy && !redirect)
               state_d = S_REQ;
         end
         S_REQ: begin
            base_d     = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd16;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            beat_d  = 2'd0;
            state_d = S_BEAT;
         end
         S_BEAT: begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A redirect overrides the +16 advance. If a burst is in flight, its
      // remaining beats are marked stale so the burst can run out harmlessly.
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         if (state_q != S_IDLE)
            drop_d = 1'b1;
      end

      if (state_d == S_IDLE)
         drop_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         beat_q     <= 2'd0;
         drop_q     <= 1'b0;
         fetch_pc_q <= RESET_PC;
         base_q     <= 32'd0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         drop_q     <= drop_d;
         fetch_pc_q <= fetch_pc_d;
         base_q     <= base_d;
      end
   end

   // ------------------------------------------------------------------ FIFO
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         rd_ptr_d = 3'd0;
         wr_ptr_d = 3'd0;
         count_d  = 4'd0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + 3'd1;
         if (pop)
            rd_ptr_d = rd_ptr_q + 3'd1;
         case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= 3'd0;
         wr_ptr_q <= 3'd0;
         count_q  <= 4'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; entries are only read when count covers them.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         fifo_inst_q[wr_ptr_q] <= mem_data_out;
         fifo_pc_q[wr_ptr_q]   <= beat_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'h80020000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_busy = 1'b0;
   logic [31:0] mem_data_out = 32'd0;
   logic        inst_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] mem_addr;
   logic        mem_enable;
   logic        mem_rd_wr;
   logic [1:0]  mem_access_size;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr),
      .mem_access_size(mem_access_size), .mem_busy(mem_busy),
      .mem_data_out(mem_data_out),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t        exp_q[$];
   ent_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   bit          sb_on = 1'b0;
   int          mphase = 0;
   logic [31:0] mbase = 32'd0;
   int          n_en;
   logic [31:0] en_log[$];

   function automatic logic [31:0] mword(input logic [31:0] a);
      case (a)
         RPC:          return 32'h11;
         RPC + 32'd4:  return 32'h22;
         RPC + 32'd8:  return 32'h33;
         RPC + 32'd12: return 32'h44;
         default:      return a ^ 32'h5A5A0000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst(input logic [31:0] base);
      for (int k = 0; k < 4; k++)
         exp_q.push_back({mword(base + 32'(4 * k)), base + 32'(4 * k)});
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      inst_ready = 1'b0;
      sb_on      = 1'b0;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      inst_ready = 1'b0;
      redirect   = 1'b0;
      sb_on      = 1'b0;
      exp_q.delete();
      repeat (3) step();
      reset = 1'b0;
   endtask

   // Memory: burst seen in cycle T, words driven for the beats in T+2..T+5.
   always @(negedge clk) begin
      if (mphase >= 2)
         mem_data_out = mword(mbase + 32'(4 * (mphase - 2)));
      if (mphase != 0)
         mphase = (mphase == 5) ? 0 : mphase + 1;
      if (mem_enable) begin
         mbase  = mem_addr;
         mphase = 1;
      end
   end

   // Scoreboard: every accepted word must match the next expected entry.
   always @(negedge clk) begin
      if (sb_on && !reset && inst_valid && inst_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_extra got pc=%h exp no output", inst_pc);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_inst", inst, mon_e.inst);
            chk("sb_pc", inst_pc, mon_e.pc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values, constants, basic burst and latency
      reset = 1'b1;
      step();
      step();
      chk("rst_en", {31'd0, mem_enable}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
      chk("rd_wr", {31'd0, mem_rd_wr}, 32'd1);
      chk("size", {30'd0, mem_access_size}, 32'd1);
      reset = 1'b0;
      chk("first_idle", {31'd0, mem_enable}, 32'd0);
      step();
      chk("first_req", {31'd0, mem_enable}, 32'd1);
      chk("first_addr", mem_addr, RPC);
      inst_ready = 1'b1;
      sb_on      = 1'b1;
      push_burst(RPC);
      push_burst(RPC + 32'd16);
      step();
      chk("lat_wait", {31'd0, inst_valid}, 32'd0);
      step();
      chk("lat_beat0", {31'd0, inst_valid}, 32'd0);
      step();
      chk("lat_valid", {31'd0, inst_valid}, 32'd1);
      drain(100);

      // ---- stalled decode: two bursts fill the FIFO, then no more requests
      do_reset();
      n_en = 0;
      en_log.delete();
      for (int i = 0; i < 40; i++) begin
         if (mem_enable) begin
            n_en++;
            en_log.push_back(mem_addr);
         end
         step();
      end
      chk("stall_bursts", 32'(n_en), 32'd2);
      if (en_log.size() == 2) begin
         chk("stall_addr0", en_log[0], RPC);
         chk("stall_addr1", en_log[1], RPC + 32'd16);
      end
      chk("full_head", inst, 32'h11);
      chk("full_pc", inst_pc, RPC);

      // ---- drain from 8: no request until the count falls to 4
      inst_ready = 1'b1;
      sb_on      = 1'b1;
      push_burst(RPC);
      push_burst(RPC + 32'd16);
      for (int i = 0; i < 5; i++) begin
         chk("hold_req", {31'd0, mem_enable}, 32'd0);
         step();
      end
      chk("req_at4", {31'd0, mem_enable}, 32'd1);
      chk("req_at4_addr", mem_addr, RPC + 32'd32);
      drain(60);

      // ---- redirect during BEAT counter 1
      do_reset();
      step();
      chk("rd_req", {31'd0, mem_enable}, 32'd1);
      step();
      step();
      step();
      chk("rd_head", inst, 32'h11);
      redirect    = 1'b1;
      redirect_pc = 32'h80020043;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rd_flushed", {31'd0, inst_valid}, 32'd0);
         chk("rd_noreq", {31'd0, mem_enable}, 32'd0);
         step();
      end
      chk("rd_newreq", {31'd0, mem_enable}, 32'd1);
      chk("rd_newaddr", mem_addr, 32'h80020040);
      inst_ready = 1'b1;
      sb_on      = 1'b1;
      push_burst(32'h80020040);
      drain(60);

      // ---- reset during WAIT abandons the burst
      do_reset();
      step();
      chk("rw_req", {31'd0, mem_enable}, 32'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rw_valid", {31'd0, inst_valid}, 32'd0);
      chk("rw_idle", {31'd0, mem_enable}, 32'd0);
      step();
      chk("rw_req2", {31'd0, mem_enable}, 32'd1);
      chk("rw_addr2", mem_addr, RPC);
      inst_ready = 1'b1;
      sb_on      = 1'b1;
      push_burst(RPC);
      drain(60);

      // ---- redirect in IDLE, then fetch across the 2^32 wrap
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFFFFF2;
      chk("ri_idle", {31'd0, mem_enable}, 32'd0);
      step();
      redirect = 1'b0;
      chk("ri_hold", {31'd0, mem_enable}, 32'd0);
      step();
      chk("ri_req", {31'd0, mem_enable}, 32'd1);
      chk("ri_addr", mem_addr, 32'hFFFFFFF0);
      inst_ready = 1'b1;
      sb_on      = 1'b1;
      push_burst(32'hFFFFFFF0);
      push_burst(32'h00000000);
      drain(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h80020000, SHALL be the byte address fetched first after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 mem_addr  output  32  SHALL carry the burst start byte address, valid while mem_enable=1.
REQ-005 mem_enable  output  1  SHALL be the one-cycle memory request strobe.
REQ-006 mem_rd_wr  output  1  SHALL be constant 1 (read only).
REQ-007 mem_access_size  output  2  SHALL be constant 2'b01 (4-word burst).
REQ-008 mem_busy  input  1  SHALL be the memory busy flag.
REQ-009 mem_data_out  input  32  SHALL be the memory read data.
REQ-010 inst  output  32  SHALL be the instruction word at the buffer head.
REQ-011 inst_pc  output  32  SHALL be the byte address of inst.
REQ-012 inst_valid  output  1  SHALL indicate inst/inst_pc are valid.
REQ-013 inst_ready  input  1  SHALL indicate the downstream decode stage accepts inst this cycle.
REQ-014 redirect  input  1  SHALL request a flush and restart of fetch at redirect_pc.
REQ-015 redirect_pc  input  32  SHALL be the restart byte address; bits [1:0] ignored (treated as 0).

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, BEAT; BEAT uses a 2-bit beat counter 0..3.
REQ-017 IDLE->REQ SHALL occur when buffer count <= 4, mem_busy=0 and redirect=0; otherwise remain in IDLE.
REQ-018 In REQ, mem_enable=1 and mem_addr=fetch_pc for exactly that cycle; fetch_pc += 16 at cycle end; next state WAIT.
REQ-019 mem_enable SHALL be 0 in every state other than REQ; mem_addr SHALL be 0 when mem_enable=0.
REQ-020 WAIT SHALL last one cycle, then BEAT with counter 0.
REQ-021 In BEAT, mem_data_out SHALL be pushed at cycle end with pc = burst base + 4*counter; after counter 3 go to IDLE.
REQ-022 Latency: REQ in cycle T -> words pushed at the ends of cycles T+2..T+5; first inst_valid=1 in T+3.
REQ-023 Buffer SHALL be an 8-entry FIFO of {inst, pc}; inst_valid = (count != 0); inst/inst_pc = head entry, driven 0 when count=0.
REQ-024 Pop SHALL occur when inst_valid=1 and inst_ready=1; simultaneous push and pop leaves count unchanged.
REQ-025 Overflow is impossible by REQ-017; the block SHALL never push into a full FIFO.
REQ-026 redirect=1 SHALL clear the FIFO (count=0) at cycle end and set fetch_pc to {redirect_pc[31:2],2'b00}; pop/push in that cycle are void.
REQ-027 redirect in REQ, WAIT or BEAT SHALL set a drop flag: the remaining beats of that burst are not pushed and the FSM completes the burst normally to IDLE; drop flag clears on entry to IDLE.
REQ-028 redirect in IDLE SHALL hold the FSM in IDLE for that cycle; the next REQ uses the new fetch_pc.
REQ-029 A second redirect during a dropped burst SHALL overwrite fetch_pc; last redirect wins.
REQ-030 fetch_pc SHALL wrap modulo 2^32 without error.

Reset
REQ-031 On reset=1: state IDLE, counter 0, drop flag 0, FIFO count 0, fetch_pc=RESET_PC, mem_enable=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0.
REQ-032 reset SHALL take priority over redirect and all handshakes; reset mid-burst abandons the burst with no pushes after reset.
REQ-033 The first REQ after reset deasserts SHALL occur in the second cycle after (IDLE one cycle, then REQ).

Verification
REQ-034 Reset, memory words 0x11,0x22,0x33,0x44 at 0x80020000..0C, inst_ready=1 -> mem_addr=0x80020000 in REQ; inst/inst_pc 0x11/0x80020000 .. 0x44/0x8002000C on consecutive cycles.
REQ-035 inst_ready=0 continuously -> exactly two bursts (0x80020000, 0x80020010), count=8, no third mem_enable.
REQ-036 redirect to 0x80020043 during first BEAT counter 1 -> FIFO empties, no later beats of that burst appear, next mem_addr=0x80020040.
REQ-037 count=5 with inst_ready=1 popping one per cycle -> REQ issued only after count reaches 4.
REQ-038 reset asserted during WAIT -> inst_valid=0 next cycle, next mem_addr=RESET_PC.
